// File: rtl/sparc_exu_rrarb_n_pkg.sv
// Shared definitions for the N-way round-robin arbiter: FSM encodings and
// the starvation threshold used when SPARC_EXU_RRARB_STARVE_DET_EN is defined.
package sparc_exu_rrarb_defs;

  typedef enum logic {
    RRARB_ST_ARB    = 1'b0,
    RRARB_ST_LOCKED = 1'b1
  } rrarb_st_e;

  localparam logic [3:0] RRARB_STARVE_MAX = 4'hF;

endpackage

// File: rtl/sparc_exu_rrarb_n_pick.sv
// Circular find-first-set: the first requesting index at or after the one-hot
// start position. The request vector is doubled, masked and folded.
module sparc_exu_rrarb_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_vec,
  input  logic [NREQ-1:0] start_vec,
  output logic [NREQ-1:0] grant_vec,
  output logic [IDW-1:0]  grant_id
);

  logic [NREQ-1:0]   therm;
  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] hit;
  logic              acc;
  logic              found;

  always_comb begin
    therm = '0;
    acc   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      acc      = acc | start_vec[i];
      therm[i] = acc;
    end
    // Lower copy only sees indices at or after start; upper copy supplies the wrap.
    dbl   = {req_vec, req_vec & therm};
    hit   = '0;
    found = 1'b0;
    for (int i = 0; i < 2*NREQ; i++) begin
      if (dbl[i] && !found) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
    end
    grant_vec = hit[NREQ-1:0] | hit[2*NREQ-1:NREQ];
    grant_id  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_vec[i]) grant_id = grant_id | IDW'(i);
    end
  end

endmodule

// File: rtl/sparc_exu_rrarb_n.sv
// N-way weighted round-robin arbiter with lock mode. Optional starvation
// detection is built when SPARC_EXU_RRARB_STARVE_DET_EN is defined.
module sparc_exu_rrarb_n
  import sparc_exu_rrarb_defs::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int WW   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               se,
  input  logic [NREQ-1:0]    req_vec,
  input  logic [NREQ*WW-1:0] weight_vec,
  input  logic               advance,
  input  logic               lock,
  output logic [NREQ-1:0]    grant_vec,
  output logic               grant_vld,
  output logic [IDW-1:0]     grant_id,
  output logic               starve
);

  logic [NREQ-1:0] last_q;
  logic [WW-1:0]   cnt_q;
  logic            stay_q;
  rrarb_st_e       st_q;

  logic [NREQ-1:0] start_vec;
  logic            hold;
  logic [WW-1:0]   w_sel;
  logic [WW-1:0]   cnt_nxt;
  logic            stay_nxt;
  logic            unused_se;

  assign unused_se = se;

  // A locked holder that still requests sits at the start point, so the
  // same picker serves both the locked and the arbitrating case.
  assign hold      = (st_q == RRARB_ST_LOCKED) && |(req_vec & last_q);
  assign start_vec = (hold || stay_q) ? last_q : {last_q[NREQ-2:0], last_q[NREQ-1]};

  sparc_exu_rrarb_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_vec   (req_vec),
    .start_vec (start_vec),
    .grant_vec (grant_vec),
    .grant_id  (grant_id)
  );

  assign grant_vld = |grant_vec;

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_vec[i]) w_sel = weight_vec[i*WW +: WW];
    end
    if ((grant_vec == last_q) && stay_q)
      cnt_nxt = (cnt_q == {WW{1'b1}}) ? cnt_q : cnt_q + WW'(1);
    else
      cnt_nxt = '0;
    stay_nxt = (cnt_nxt < w_sel);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= {1'b1, {(NREQ-1){1'b0}}};
      cnt_q  <= '0;
      stay_q <= 1'b0;
      st_q   <= RRARB_ST_ARB;
    end else if (advance && grant_vld) begin
      last_q <= grant_vec;
      cnt_q  <= cnt_nxt;
      stay_q <= stay_nxt;
      st_q   <= lock ? RRARB_ST_LOCKED : RRARB_ST_ARB;
    end else if ((st_q == RRARB_ST_LOCKED) && !hold) begin
      st_q <= RRARB_ST_ARB;
    end
  end

`ifdef SPARC_EXU_RRARB_STARVE_DET_EN
  logic [NREQ-1:0][3:0] wait_q;
  logic [NREQ-1:0]      at_max;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_vec[i] && !grant_vec[i]) begin
          if (wait_q[i] != RRARB_STARVE_MAX) wait_q[i] <= wait_q[i] + 4'd1;
        end else begin
          wait_q[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    at_max = '0;
    for (int i = 0; i < NREQ; i++) at_max[i] = (wait_q[i] == RRARB_STARVE_MAX);
  end

  assign starve = |at_max;
`else
  assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_sparc_exu_rrarb_n.sv
// Directed bench for sparc_exu_rrarb_n (NREQ=4, IDW=2, WW=2); the starvation
// section is exercised when SPARC_EXU_RRARB_STARVE_DET_EN is defined.
module tb_sparc_exu_rrarb_n;

  logic       clk = 1'b0;
  logic       reset;
  logic       se;
  logic [3:0] req_vec;
  logic [7:0] weight_vec;
  logic       advance;
  logic       lock;
  logic [3:0] grant_vec;
  logic       grant_vld;
  logic [1:0] grant_id;
  logic       starve;

  int checks = 0;
  int errors = 0;

  sparc_exu_rrarb_n #(.NREQ(4), .IDW(2), .WW(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .se         (se),
    .req_vec    (req_vec),
    .weight_vec (weight_vec),
    .advance    (advance),
    .lock       (lock),
    .grant_vec  (grant_vec),
    .grant_vld  (grant_vld),
    .grant_id   (grant_id),
    .starve     (starve)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, let combinational outputs settle, check the grant.
  task automatic grant_step(input string tag, input logic [3:0] req, input logic adv,
                            input logic lk, input logic [1:0] exp_id);
    req_vec = req;
    advance = adv;
    lock    = lk;
    #1;
    chk({tag, "_id"}, 32'(grant_id), 32'(exp_id));
    chk({tag, "_vld"}, 32'(grant_vld), 32'd1);
    chk({tag, "_vec"}, 32'(grant_vec), 32'(4'b0001 << exp_id));
    cyc();
  endtask

  int unsigned exp_seq_a [5] = '{0, 1, 2, 3, 0};
  int unsigned exp_seq_w [7] = '{0, 1, 1, 1, 2, 3, 0};

  initial begin
    reset = 1'b1; se = 1'b0; req_vec = '0; weight_vec = '0; advance = 1'b0; lock = 1'b0;
    cyc();
    cyc();
    chk("rst_gvec", 32'(grant_vec), 32'd0);
    chk("rst_vld", 32'(grant_vld), 32'd0);
    chk("rst_id", 32'(grant_id), 32'd0);
    chk("rst_starve", 32'(starve), 32'd0);
    chk("rst_st", 32'(dut.st_q), 32'd0);
    chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
    reset = 1'b0;
    cyc();

    for (int i = 0; i < 5; i++) grant_step("rr", 4'b1111, 1'b1, 1'b0, 2'(exp_seq_a[i]));

    // Advancing with nothing requested must not disturb the pointer.
    for (int i = 0; i < 3; i++) begin
      req_vec = 4'b0000; advance = 1'b1; lock = 1'b0;
      #1;
      chk("idle_gvec", 32'(grant_vec), 32'd0);
      chk("idle_vld", 32'(grant_vld), 32'd0);
      chk("idle_id", 32'(grant_id), 32'd0);
      cyc();
    end
    grant_step("resume", 4'b1111, 1'b1, 1'b0, 2'd1);
    grant_step("resume", 4'b1111, 1'b1, 1'b0, 2'd2);
    grant_step("resume", 4'b1111, 1'b1, 1'b0, 2'd3);

    weight_vec = 8'b00_00_10_00;
    for (int i = 0; i < 7; i++) begin
      grant_step("wgt", 4'b1111, 1'b1, 1'b0, 2'(exp_seq_w[i]));
      if (i == 3) chk("wgt_cnt", 32'(dut.cnt_q), 32'd2);
    end
    weight_vec = '0;

    grant_step("pre_lock", 4'b1111, 1'b1, 1'b0, 2'd1);
    grant_step("lock_take", 4'b1111, 1'b1, 1'b1, 2'd2);
    chk("lock_st", 32'(dut.st_q), 32'd1);
    for (int i = 0; i < 4; i++) grant_step("lock_hold", 4'b1111, 1'b1, 1'b1, 2'd2);
    grant_step("lock_drop", 4'b1011, 1'b0, 1'b1, 2'd3);
    chk("drop_st", 32'(dut.st_q), 32'd0);

    grant_step("lock3", 4'b1111, 1'b1, 1'b1, 2'd3);
    chk("lock3_st", 32'(dut.st_q), 32'd1);
    reset = 1'b1; req_vec = 4'b1111; advance = 1'b1; lock = 1'b1;
    cyc();
    reset = 1'b0; advance = 1'b0; lock = 1'b0;
    #1;
    chk("rst_lock_id", 32'(grant_id), 32'd0);
    chk("rst_lock_st", 32'(dut.st_q), 32'd0);
    chk("rst_lock_cnt", 32'(dut.cnt_q), 32'd0);

    // Requestor 0 is locked while requestor 1 waits.
    req_vec = 4'b0011; advance = 1'b1; lock = 1'b1;
    #1;
    chk("stv_id0", 32'(grant_id), 32'd0);
    chk("stv_init", 32'(starve), 32'd0);
    for (int e = 1; e <= 15; e++) begin
      cyc();
      chk("stv_hold_id", 32'(grant_id), 32'd0);
`ifdef SPARC_EXU_RRARB_STARVE_DET_EN
      chk("stv_flag", 32'(starve), (e == 15) ? 32'd1 : 32'd0);
`else
      chk("stv_flag", 32'(starve), 32'd0);
`endif
    end
    lock = 1'b0;
    cyc();
    #1;
    chk("stv_rel_id", 32'(grant_id), 32'd1);
`ifdef SPARC_EXU_RRARB_STARVE_DET_EN
    chk("stv_still", 32'(starve), 32'd1);
`else
    chk("stv_still", 32'(starve), 32'd0);
`endif
    cyc();
    chk("stv_clear", 32'(starve), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sparc_exu_rrarb_n.md
Name: sparc_exu_rrarb_n

Overview:
- Parametrised N-way round-robin arbiter for EXU shared resources (ECL/IRF write port, div/mul unit, thread select across NREQ strands).
- Extends the fixed 4-way scheduler with:
  - an N-wide request vector;
  - a per-requestor weight, so a requestor may take up to weight+1 consecutive grants;
  - a lock mode that parks the grant on one requestor across multi-cycle operations;
  - a valid/encoded grant output.
- Grant is combinational from the current request and registered state. State advances only on `advance`.

Parameters:
- NREQ, 4, number of requestors (2..16).
- IDW, 2, width of encoded grant id; must satisfy 2**IDW >= NREQ.
- WW, 2, width of each per-requestor weight field and of the burst counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- se  in  1  scan enable, passed to flops; no functional effect.
- req_vec  in  NREQ  request per requestor.
- weight_vec  in  NREQ*WW  field i, at bits [i*WW +: WW], is the extra consecutive grants allowed to requestor i; quasi-static.
- advance  in  1  grant consumed this cycle; update state.
- lock  in  1  with advance: hold the current winner after this cycle.
- grant_vec  out  NREQ  one-hot grant, or zero.
- grant_vld  out  1  OR of grant_vec.
- grant_id  out  IDW  binary index of the granted requestor; 0 when grant_vld is 0.
- starve  out  1  starvation flag; present only with the optional feature, otherwise tied to 0.

Behaviour:
- Registered state:
  - last_q (NREQ, one-hot): reset value has bit NREQ-1 set, so requestor 0 has highest priority after reset.
  - cnt_q (WW): reset value 0.
  - stay_q (1): reset value 0.
  - st_q (FSM): reset value ARB.
- Reset is synchronous. When reset is asserted, all state returns to reset values on the next edge regardless of advance or lock. Reset asserted mid-lock drops the lock.
- Outputs are combinational (zero latency) from req_vec and state. With reset held and req_vec=0, all outputs are 0.
- No requests: grant_vec=0, grant_vld=0, grant_id=0. This differs from the 4-way block, which defaulted to requestor 0. Advance with no grant leaves all state unchanged.
- FSM st_q, two states: ARB and LOCKED.
- ARB, search start:
  - If stay_q=1, search begins at last_q.
  - Otherwise search begins at the requestor after last_q, modulo NREQ, with wrap-around NREQ-1 -> 0.
  - Grant goes to the first requesting index in circular order from the start point.
- LOCKED:
  - If req_vec & last_q is nonzero, grant = last_q.
  - Otherwise, ARB arbitration applies this cycle (holder dropped its request).
- On advance with grant g (index k):
  - last_q <= g.
  - cnt_q <= (g==last_q && stay_q) ? cnt_q+1 : 0. Counter saturates and never wraps.
  - stay_q <= (next cnt_q < weight[k]).
  - Weight 0 gives pure round-robin. Weight w gives w+1 back-to-back grants while requesting.
- FSM transitions, evaluated on advance with grant_vld=1:
  - ARB -> LOCKED if lock=1.
  - LOCKED -> ARB if lock=0.
  - LOCKED -> LOCKED if lock=1.
- LOCKED also exits to ARB, without advance, when the holder's request drops for one cycle.
- Weight changes take effect on the next advance. A weight lowered below cnt_q clears stay_q at that advance.
- Grant is always one-hot or zero. It never selects a non-requesting index.

Optional Feature:
- Macro: SPARC_EXU_RRARB_STARVE_DET_EN.
- When defined:
  - Per-requestor 4-bit saturating wait counters.
  - Counter i increments each cycle req_vec[i]=1 && grant_vec[i]=0.
  - Counter i clears on grant to i, or when req_vec[i]=0.
  - starve=1 whenever any counter is at 15.
  - Counters reset to 0.
- When undefined: no counters; starve is constant 0.

Decomposition:
- Shared package/include sparc_exu_rrarb_defs:
  - FSM state encodings RRARB_ST_ARB=1'b0 and RRARB_ST_LOCKED=1'b1.
  - Starvation threshold constant RRARB_STARVE_MAX=4'hF.
- One natural sub-module, sparc_exu_rrarb_pick: combinational circular find-first-set. Inputs are req_vec and a one-hot start vector; outputs are the one-hot grant and the encoded id. Implement by doubling req_vec to 2*NREQ, masking, and folding.
- Top level holds the state flops (dffr_s style), FSM, counters and the optional starvation logic.

Test Plan:
- Reset, then req_vec=4'b1111, weights 0, advance every cycle -> grant_id sequence 0,1,2,3,0; grant_vld=1 throughout.
- req_vec=0 for 3 cycles with advance=1 -> grant_vec=0, grant_vld=0. State unchanged, so the next req_vec=4'b1111 grants the index after the last winner.
- weight_vec field 1 = 2, others 0, all requesting, advance every cycle -> grant_id sequence 0,1,1,1,2,3,0.
- Grant to 2 with lock=1, then req_vec=4'b1111 for 4 cycles with lock=1 -> grant_id=2 held. Drop req_vec[2] -> grant moves to 3 that cycle and st_q returns to ARB.
- Assert reset while LOCKED on requestor 3 -> next cycle with req_vec=4'b1111 gives grant_id=0, st_q=ARB, cnt_q=0.
- With SPARC_EXU_RRARB_STARVE_DET_EN defined: req_vec=4'b0011, lock held on requestor 0 for 16 cycles -> starve rises after 15 cycles of requestor 1 waiting, and clears the cycle after requestor 1 is granted.
